// File: rtl/fpu_request_engine.sv
// Request engine that streams a 2-D window between memory and the FPU
// line buffers, one 32-bit beat at a time.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   read, write         fill read buffer / drain write buffer requests
//   read_address        base byte address of the read window
//   write_address       base byte address of the write window
//   width, height       bytes per row, result rows
//   input_row_width     byte stride between image rows
//   making_request      high while a transfer is pending or in progress
//   mem_*               single-beat memory request/ack port
//   buf_wr_*            read-buffer write port
//   wb_rd_*, wb_rdata   write-buffer read port (data one cycle after address)
module fpu_request_engine #(
    parameter int COL_WIDTH        = 10,
    parameter int MEM_BUFFER_WIDTH = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [9:0]  width,
    input  logic [7:0]  height,
    input  logic [18:0] input_row_width,
    output logic        making_request,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        buf_wr_en,
    output logic [7:0]  buf_wr_row,
    output logic [$clog2(MEM_BUFFER_WIDTH)-1:0] buf_wr_col,
    output logic [31:0] buf_wdata,
    output logic [7:0]  wb_rd_row,
    output logic [$clog2(MEM_BUFFER_WIDTH)-1:0] wb_rd_col,
    input  logic [31:0] wb_rdata
);

    localparam int CW = $clog2(MEM_BUFFER_WIDTH);

    // Buffer height only bounds what a caller may ask for in height;
    // no logic here depends on it.
    logic unused_col_width;
    assign unused_col_width = (COL_WIDTH > 0);

    typedef enum logic [2:0] {
        IDLE,
        WR_FETCH,
        WR_REQ,
        RD_REQ,
        DONE
    } state_t;

    state_t state, state_nx;

    logic        lat_read, lat_write;
    logic [31:0] rd_addr_q, wr_addr_q;
    logic [9:0]  width_q;
    logic [7:0]  height_q;
    logic [18:0] stride_q;

    logic [8:0]  row_q, row_nx;
    logic [8:0]  beat_q, beat_nx;
    logic [31:0] base_q, base_nx;
    logic [31:0] wdata_q, wdata_nx;
    logic        first_q, first_nx;
    logic        gap_q, gap_nx;

    logic [10:0] col_full;
    logic [10:0] next_col;
    logic        last_beat;
    logic        wr_last_row;
    logic        rd_last_row;
    logic        wr_empty;
    logic        rd_empty;
    logic [31:0] beat_addr;
    logic [31:0] next_base;
    logic        accept;

    assign accept      = (state == IDLE) && (read || write);
    assign col_full    = {beat_q, 2'b00};
    assign next_col    = col_full + 11'd4;
    // Last beat of a row once the next column would reach width.
    assign last_beat   = next_col >= {1'b0, width_q};
    assign wr_last_row = row_q == ({1'b0, height_q} - 9'd1);
    // The read pass covers height+2 rows.
    assign rd_last_row = row_q == ({1'b0, height_q} + 9'd1);
    assign wr_empty    = (width_q == 10'd0) || (height_q == 8'd0);
    assign rd_empty    = (width_q == 10'd0);
    assign beat_addr   = base_q + {21'd0, col_full};
    assign next_base   = base_q + {13'd0, stride_q};

    always_comb begin
        state_nx       = state;
        row_nx         = row_q;
        beat_nx        = beat_q;
        base_nx        = base_q;
        wdata_nx       = wdata_q;
        first_nx       = first_q;
        gap_nx         = gap_q;
        making_request = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 32'd0;
        mem_wdata      = 32'd0;
        buf_wr_en      = 1'b0;
        buf_wr_row     = 8'd0;
        buf_wr_col     = '0;
        buf_wdata      = 32'd0;
        wb_rd_row      = 8'd0;
        wb_rd_col      = '0;

        unique case (state)
            IDLE: begin
                if (read || write) begin
                    row_nx   = 9'd0;
                    beat_nx  = 9'd0;
                    base_nx  = write ? write_address : read_address;
                    first_nx = 1'b0;
                    gap_nx   = 1'b0;
                    state_nx = write ? WR_FETCH : RD_REQ;
                end
            end

            WR_FETCH: begin
                making_request = 1'b1;
                if (wr_empty) begin
                    if (lat_read && !rd_empty) begin
                        row_nx   = 9'd0;
                        beat_nx  = 9'd0;
                        base_nx  = rd_addr_q;
                        gap_nx   = 1'b0;
                        state_nx = RD_REQ;
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    wb_rd_row = row_q[7:0];
                    wb_rd_col = CW'(col_full);
                    first_nx  = 1'b1;
                    state_nx  = WR_REQ;
                end
            end

            WR_REQ: begin
                making_request = 1'b1;
                mem_req        = 1'b1;
                mem_we         = 1'b1;
                mem_addr       = beat_addr;
                // Buffer data is live only in the first cycle; hold a copy
                // so the beat stays stable while waiting for the ack.
                mem_wdata      = first_q ? wb_rdata : wdata_q;
                first_nx       = 1'b0;
                if (first_q) begin
                    wdata_nx = wb_rdata;
                end
                if (mem_ack) begin
                    if (!last_beat) begin
                        beat_nx  = beat_q + 9'd1;
                        state_nx = WR_FETCH;
                    end else if (!wr_last_row) begin
                        row_nx   = row_q + 9'd1;
                        beat_nx  = 9'd0;
                        base_nx  = next_base;
                        state_nx = WR_FETCH;
                    end else if (lat_read) begin
                        row_nx   = 9'd0;
                        beat_nx  = 9'd0;
                        base_nx  = rd_addr_q;
                        gap_nx   = 1'b1;
                        state_nx = RD_REQ;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end

            RD_REQ: begin
                making_request = 1'b1;
                if (rd_empty) begin
                    state_nx = DONE;
                end else if (gap_q) begin
                    gap_nx = 1'b0;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = beat_addr;
                    if (mem_ack) begin
                        buf_wr_en  = 1'b1;
                        buf_wr_row = row_q[7:0];
                        buf_wr_col = CW'(col_full);
                        buf_wdata  = mem_rdata;
                        gap_nx     = 1'b1;
                        if (!last_beat) begin
                            beat_nx = beat_q + 9'd1;
                        end else if (!rd_last_row) begin
                            row_nx  = row_q + 9'd1;
                            beat_nx = 9'd0;
                            base_nx = next_base;
                        end else begin
                            state_nx = DONE;
                        end
                    end
                end
            end

            DONE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            rd_addr_q <= 32'd0;
            wr_addr_q <= 32'd0;
            width_q   <= 10'd0;
            height_q  <= 8'd0;
            stride_q  <= 19'd0;
            row_q     <= 9'd0;
            beat_q    <= 9'd0;
            base_q    <= 32'd0;
            wdata_q   <= 32'd0;
            first_q   <= 1'b0;
            gap_q     <= 1'b0;
        end else begin
            state   <= state_nx;
            row_q   <= row_nx;
            beat_q  <= beat_nx;
            base_q  <= base_nx;
            wdata_q <= wdata_nx;
            first_q <= first_nx;
            gap_q   <= gap_nx;
            if (accept) begin
                lat_read  <= read;
                lat_write <= write;
                rd_addr_q <= read_address;
                wr_addr_q <= write_address;
                width_q   <= width;
                height_q  <= height;
                stride_q  <= input_row_width;
            end else if (state == DONE) begin
                lat_read  <= 1'b0;
                lat_write <= 1'b0;
            end
        end
    end

    // Write base is consumed at acceptance; the copy keeps the latched
    // request complete for debug visibility.
    logic unused_latch;
    assign unused_latch = ^{lat_write, wr_addr_q};

endmodule
